// File: rtl/fir_sample_ring.sv
// Sample history ring for an FIR engine, stored in an external single-port dmem.
// Tap reads take priority over sample writes; every tap result arrives exactly three cycles after its request.
module fir_sample_ring #(
   parameter int DEPTH = 10240,
   parameter int AW    = 14,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_ofs,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic [AW-1:0] count,
   output logic          mem_cen,
   output logic          mem_wen,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d,
   input  logic [DW-1:0] mem_q
);

   localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_X   = (AW+1)'(1);
   localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   logic [AW-1:0] wp;
   logic [AW-1:0] wp_next;
   logic          wr_acc;
   logic          rd_hit;
   logic [AW:0]   rd_sum;
   logic [AW-1:0] rd_addr;
   logic          s1_v, s1_hit, s2_v, s2_hit;

   // Handshake: a sample transfers on a rising edge where in_valid && in_ready; a tap
   // request (rd_req) is always taken and owns the memory slot, so it deasserts in_ready.
   assign in_ready = rst_n & ~rd_req & ~clr;
   assign wr_acc   = in_valid & in_ready;
   assign rd_hit   = rd_req & ~clr & (rd_ofs < count);

   // Newest sample lives at wp-1; the sum is kept non-negative by adding DEPTH first.
   assign rd_sum  = {1'b0, wp} + DEPTH_X - ONE_X - {1'b0, rd_ofs};
   assign rd_addr = (rd_sum >= DEPTH_X) ? AW'(rd_sum - DEPTH_X) : AW'(rd_sum);
   assign wp_next = (wp == LAST) ? '0 : wp + AW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         count <= '0;
      end else if (clr) begin
         wp    <= '0;
         count <= '0;
      end else if (wr_acc) begin
         wp <= wp_next;
         if (count != DEPTH_C) count <= count + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_cen <= 1'b1;
         mem_wen <= 1'b1;
         mem_a   <= '0;
         mem_d   <= '0;
      end else begin
         mem_cen <= 1'b1;
         mem_wen <= 1'b1;
         mem_a   <= '0;
         mem_d   <= '0;
         if (rd_hit) begin
            mem_cen <= 1'b0;
            mem_a   <= rd_addr;
         end else if (wr_acc) begin
            mem_cen <= 1'b0;
            mem_wen <= 1'b0;
            mem_a   <= wp;
            mem_d   <= in_data;
         end
      end
   end

   // Misses travel the same pipeline as hits so results stay in request order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v     <= 1'b0;
         s1_hit   <= 1'b0;
         s2_v     <= 1'b0;
         s2_hit   <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         s1_v     <= rd_req;
         s1_hit   <= rd_hit;
         s2_v     <= s1_v;
         s2_hit   <= s1_hit;
         rd_valid <= s2_v;
         rd_data  <= s2_hit ? mem_q : '0;
      end
   end

endmodule

// File: tb/tb_fir_sample_ring.sv
// Bench for fir_sample_ring: an attached dmem, a sample-history model checked every cycle,
// and directed scenarios with literal expectations.
module tb_fir_sample_ring;
   localparam int DEPTH = 10240;
   localparam int AW    = 14;
   localparam int DW    = 16;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          clr      = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          rd_req   = 1'b0;
   logic [AW-1:0] rd_ofs   = '0;
   logic          in_ready, rd_valid, mem_cen, mem_wen;
   logic [DW-1:0] rd_data, mem_d, mem_q;
   logic [AW-1:0] count, mem_a;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fir_sample_ring #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rd_req(rd_req), .rd_ofs(rd_ofs), .rd_valid(rd_valid), .rd_data(rd_data),
      .count(count), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a),
      .mem_d(mem_d), .mem_q(mem_q)
   );

   // attached single-port dmem, read data one cycle after the command
   logic [DW-1:0] dmem [0:DEPTH-1];
   always @(posedge clk) begin
      if (!mem_cen) begin
         if (!mem_wen) dmem[mem_a] <= mem_d;
         else          mem_q <= dmem[mem_a];
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: hist[k] is x[n-k]; results ride a three-deep delay line
   logic [DW-1:0] hist[$];
   int            wr_idx = 0;
   bit            pv[3];
   int            pd[3];
   bit            started = 1'b0;
   bit            e_rv = 1'b0;
   int            e_rd = 0, e_cen = 1, e_wen = 1, e_a = 0, e_d = 0;
   bit            nv;
   int            nd;

   always @(posedge clk) begin
      started = 1'b1;
      e_cen = 1; e_wen = 1; e_a = 0; e_d = 0;
      if (!rst_n) begin
         hist.delete();
         wr_idx = 0;
         for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = 0; end
         e_rv = 1'b0;
         e_rd = 0;
      end else begin
         nv = rd_req;
         nd = 0;
         if (rd_req) begin
            if (!clr && int'(rd_ofs) < hist.size()) begin
               nd    = int'(hist[rd_ofs]);
               e_cen = 0;
               e_a   = (wr_idx - 1 - int'(rd_ofs) + DEPTH) % DEPTH;
            end
         end else if (in_valid && !clr) begin
            e_cen = 0; e_wen = 0; e_a = wr_idx; e_d = int'(in_data);
            hist.push_front(in_data);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            wr_idx = (wr_idx + 1) % DEPTH;
         end
         pv[2] = pv[1]; pd[2] = pd[1];
         pv[1] = pv[0]; pd[1] = pd[0];
         pv[0] = nv;    pd[0] = nd;
         e_rv = pv[2];
         e_rd = pd[2];
         if (clr) begin
            hist.delete();
            wr_idx = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         if (!rst_n) begin
            check("rst_rd_valid", int'(rd_valid), 0);
            check("rst_rd_data", int'(rd_data), 0);
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_count", int'(count), 0);
            check("rst_mem_cen", int'(mem_cen), 1);
            check("rst_mem_wen", int'(mem_wen), 1);
            check("rst_mem_a", int'(mem_a), 0);
            check("rst_mem_d", int'(mem_d), 0);
         end else begin
            check("in_ready", int'(in_ready), int'(!rd_req && !clr));
            check("count", int'(count), hist.size());
            check("rd_valid", int'(rd_valid), int'(e_rv));
            if (e_rv) check("rd_data", int'(rd_data), e_rd);
            check("mem_cen", int'(mem_cen), e_cen);
            check("mem_wen", int'(mem_wen), e_wen);
            check("mem_a", int'(mem_a), e_a);
            if (!(e_cen == 0 && e_wen == 1)) check("mem_d", int'(mem_d), e_d);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int v);
      in_valid = 1'b1;
      in_data  = DW'(v);
      step();
      in_valid = 1'b0;
   endtask

   task automatic rd_chk(input int ofs, input int exp, input string name);
      rd_req = 1'b1;
      rd_ofs = AW'(ofs);
      step();
      rd_req = 1'b0;
      step();
      step();
      #3;
      check({name, "_valid"}, int'(rd_valid), 1);
      check(name, int'(rd_data), exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      int v;
      // reset state
      step(); step();
      #3;
      check("reset_mem_cen", int'(mem_cen), 1);
      check("reset_count", int'(count), 0);
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_rd_valid", int'(rd_valid), 0);
      step();
      rst_n = 1'b1;
      step();

      // three writes then taps 0/1/2 back to back
      wr(9000); #3;
      check("w0_a", int'(mem_a), 0); check("w0_wen", int'(mem_wen), 0); check("w0_d", int'(mem_d), 9000);
      wr(300); #3;
      check("w1_a", int'(mem_a), 1); check("w1_d", int'(mem_d), 300);
      wr(50); #3;
      check("w2_a", int'(mem_a), 2); check("w2_cnt", int'(count), 3);
      step();
      rd_req = 1'b1; rd_ofs = 0; step();
      rd_ofs = 1; step();
      rd_ofs = 2; step();
      rd_req = 1'b0; #3;
      check("tap0_valid", int'(rd_valid), 1); check("tap0", int'(rd_data), 50);
      step(); #3; check("tap1", int'(rd_data), 300);
      step(); #3; check("tap2", int'(rd_data), 9000);
      step();

      // out-of-range taps zero-pad without touching dmem
      rd_req = 1'b1; rd_ofs = 3; step(); #3;
      check("pad3_cen", int'(mem_cen), 1);
      rd_ofs = 12; step();
      rd_req = 1'b0; #3;
      check("pad12_cen", int'(mem_cen), 1);
      step(); #3; check("pad3_valid", int'(rd_valid), 1); check("pad3", int'(rd_data), 0);
      step(); #3; check("pad12_valid", int'(rd_valid), 1); check("pad12", int'(rd_data), 0);
      step();

      // streaming writes interrupted by two tap reads; the held sample must not be lost
      v = 100;
      in_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         rd_req  = (c == 3 || c == 4);
         rd_ofs  = (c == 4) ? AW'(1) : AW'(0);
         in_data = DW'(v);
         step();
         if (c != 3 && c != 4) v++;
      end
      in_valid = 1'b0;
      rd_req   = 1'b0;
      step(); step(); step();
      check("stream_cnt", int'(count), 9);
      rd_chk(0, 105, "stream_new");
      rd_chk(5, 100, "stream_old");
      rd_chk(2, 103, "stream_held");

      // clr with two reads in flight
      rd_req = 1'b1; rd_ofs = 0; step();
      rd_ofs = 2; step();
      rd_req = 1'b0; clr = 1'b1; step();
      clr = 1'b0; #3;
      check("clr_rd0_valid", int'(rd_valid), 1); check("clr_rd0", int'(rd_data), 105);
      check("clr_cnt", int'(count), 0);
      step(); #3;
      check("clr_rd1", int'(rd_data), 103);
      wr(777); #3;
      check("clr_wr_a", int'(mem_a), 0); check("clr_wr_wen", int'(mem_wen), 0);
      step();

      // fill past DEPTH: wrap and count saturation
      clr = 1'b1; step(); clr = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         in_data = DW'(i);
         step();
      end
      in_data = DW'(DEPTH);
      step();
      in_valid = 1'b0; #3;
      check("wrap_a", int'(mem_a), 0); check("wrap_d", int'(mem_d), DEPTH);
      check("sat_cnt", int'(count), DEPTH);
      step();
      rd_chk(0, DEPTH, "full_new");
      rd_chk(DEPTH - 1, 1, "full_old");
      rd_chk(DEPTH, 0, "full_pad");
      rd_chk(16383, 0, "full_pad_max");
      check("sat_cnt_hold", int'(count), DEPTH);

      // reset in the middle of a read burst
      rd_req = 1'b1; rd_ofs = 0; step();
      rd_ofs = 1; step();
      rd_req = 1'b0; rst_n = 1'b0; step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); #3;
         check("rst_burst_valid", int'(rd_valid), 0);
         check("rst_burst_cen", int'(mem_cen), 1);
         check("rst_burst_a", int'(mem_a), 0);
      end
      check("rst_burst_cnt", int'(count), 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fir_sample_ring.md
FIR_SAMPLE_RING -- requirements
Module: fir_sample_ring

Interface
REQ-001 Parameter DEPTH, default 10240: number of sample words in the attached dmem.
REQ-002 Parameter AW, default 14: dmem address width.
REQ-003 Parameter DW, default 16: sample and data width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 clr  input  1  synchronous flush of ring state, active-high.
REQ-007 in_valid  input  1  upstream sample valid.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_data  input  DW  incoming sample x[n].
REQ-010 rd_req  input  1  tap read request, always accepted.
REQ-011 rd_ofs  input  AW  tap offset k; requests x[n-k].
REQ-012 rd_valid  output  1  rd_data valid, one-cycle pulse per request.
REQ-013 rd_data  output  DW  registered tap sample.
REQ-014 count  output  AW  number of valid samples stored, saturating at DEPTH.
REQ-015 mem_cen  output  1  dmem chip enable, active-low.
REQ-016 mem_wen  output  1  dmem write enable, active-low (0 = write, 1 = read).
REQ-017 mem_a  output  AW  dmem address.
REQ-018 mem_d  output  DW  dmem write data.
REQ-019 mem_q  input  DW  dmem read data, valid the cycle after a read command.

Function
REQ-020 The block SHALL issue at most one dmem command per cycle, via registered mem_cen/mem_wen/mem_a/mem_d.
REQ-021 in_ready SHALL equal rst_n AND NOT rd_req AND NOT clr (combinational); a read always wins the memory slot.
REQ-022 On a write accept (in_valid and in_ready) in cycle t, cycle t+1 SHALL drive mem_cen=0, mem_wen=0, mem_a=wp, mem_d=in_data.
REQ-023 wp SHALL advance on each write accept and wrap from DEPTH-1 to 0; count SHALL increment, saturating at DEPTH.
REQ-024 On rd_req in cycle t with rd_ofs < count (count and wp sampled at the start of cycle t), cycle t+1 SHALL drive mem_cen=0, mem_wen=1, mem_a=(wp-1-rd_ofs) mod DEPTH.
REQ-025 For a valid read, mem_q SHALL be captured at the end of cycle t+2; rd_valid=1 and rd_data=that value in cycle t+3.
REQ-026 On rd_req with rd_ofs >= count (including rd_ofs >= DEPTH), no dmem command SHALL be issued (mem_cen=1), and rd_valid=1 with rd_data=0 in cycle t+3 (zero-padding).
REQ-027 Back-to-back rd_req SHALL be fully pipelined at one result per cycle, in request order, latency 3.
REQ-028 A sample accepted in cycle t SHALL be returned as rd_ofs=0 by any rd_req in cycle t+1 or later.
REQ-029 In cycles with no command, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0.
REQ-030 clr SHALL set wp=0 and count=0 at the next edge; in-flight reads still complete with their already-issued result.
REQ-031 An rd_req in a clr cycle SHALL be treated as count=0 and return 0.
REQ-032 Modular address arithmetic SHALL be performed in AW+1 bits, so DEPTH need not be a power of two.

Reset
REQ-033 While rst_n=0: wp=0, count=0, rd_valid=0, rd_data=0, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0, in_ready=0, read pipeline emptied.
REQ-034 Reset assertion mid-operation SHALL abort pending reads with no rd_valid pulse and no stray dmem command.

Verification
REQ-035 Reset, then write 9000, 300, 50 -> mem_a=0/1/2, mem_wen=0, count=3; rd_ofs=0/1/2 -> rd_data 50/300/9000 at latency 3.
REQ-036 After 3 samples, rd_ofs=3 and rd_ofs=12 -> mem_cen stays 1; rd_valid pulses with rd_data=0.
REQ-037 Write 10241 samples (value = index) -> count=10240, last write at mem_a=0; rd_ofs=0 -> 10240, rd_ofs=10239 -> 1.
REQ-038 Hold in_valid=1 and pulse rd_req for 2 cycles -> in_ready=0 during those 2 cycles, no write lost, reads return in order.
REQ-039 Issue clr with 2 reads in flight -> both reads return their pre-clr data, count=0, next write goes to mem_a=0.
REQ-040 Assert rst_n=0 for one cycle mid-read burst -> no rd_valid after reset, and all mem outputs are idle.
